// File: rtl/loproc_alu_ctrl.sv
// LoPROC ALU sequencing controller. It drives the ALU operands and control word,
// registers each result and keeps the Z/N/C/V flags. MUL runs as a 32-step shift-add loop.
module loproc_alu_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            op_code,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] alu_x,
    output logic [DATA_WIDTH-1:0] alu_y,
    output logic                  alu_zx,
    output logic                  alu_zy,
    output logic                  alu_nx,
    output logic                  alu_ny,
    output logic                  alu_f,
    output logic                  alu_l,
    output logic                  alu_cs,
    output logic                  alu_asel,
    output logic                  alu_cin,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  alu_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_wr,
    output logic                  res_err,
    output logic                  flag_z,
    output logic                  flag_n,
    output logic                  flag_c,
    output logic                  flag_v
);

    localparam int MSB = DATA_WIDTH - 1;
    localparam int CW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADC   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_SBC   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_OR    = 4'h5;
    localparam logic [3:0] OP_XOR   = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_NEG   = 4'h8;
    localparam logic [3:0] OP_INC   = 4'h9;
    localparam logic [3:0] OP_DEC   = 4'hA;
    localparam logic [3:0] OP_PASSA = 4'hB;
    localparam logic [3:0] OP_PASSB = 4'hC;
    localparam logic [3:0] OP_CMP   = 4'hD;
    localparam logic [3:0] OP_MUL   = 4'hE;
    localparam logic [3:0] OP_ILL   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            opc_q, opc_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_wr_q, res_wr_d;
    logic                  res_err_q, res_err_d;
    logic                  flag_z_q, flag_z_d;
    logic                  flag_n_q, flag_n_d;
    logic                  flag_c_q, flag_c_d;
    logic                  flag_v_q, flag_v_d;

    logic carry_op;
    logic add_v_op;
    logic sub_v_op;
    logic v_add;
    logic v_sub;

    assign carry_op = opc_q inside {OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_NEG, OP_INC, OP_DEC, OP_CMP};
    assign add_v_op = opc_q inside {OP_ADD, OP_ADC};
    assign sub_v_op = opc_q inside {OP_SUB, OP_SBC, OP_CMP};
    assign v_add    = (a_q[MSB] == b_q[MSB]) && (alu_out[MSB] != a_q[MSB]);
    assign v_sub    = (a_q[MSB] != b_q[MSB]) && (alu_out[MSB] != a_q[MSB]);

    // ALU operand/control drive: only EXEC and MUL ever present a non-zero word.
    always_comb begin
        alu_x    = '0;
        alu_y    = '0;
        alu_zx   = 1'b0;
        alu_zy   = 1'b0;
        alu_nx   = 1'b0;
        alu_ny   = 1'b0;
        alu_f    = 1'b0;
        alu_l    = 1'b0;
        alu_cs   = 1'b0;
        alu_asel = 1'b0;
        alu_cin  = 1'b0;
        case (state_q)
            S_EXEC: begin
                if (opc_q != OP_ILL) begin
                    alu_x = a_q;
                    alu_y = b_q;
                end
                case (opc_q)
                    OP_ADD:   alu_f = 1'b1;
                    OP_ADC:   begin alu_f = 1'b1; alu_cs = 1'b1; alu_cin = flag_c_q; end
                    OP_SUB,
                    OP_CMP:   begin alu_ny = 1'b1; alu_f = 1'b1; alu_cs = 1'b1; alu_cin = 1'b1; end
                    OP_SBC:   begin alu_ny = 1'b1; alu_f = 1'b1; alu_cs = 1'b1; alu_cin = flag_c_q; end
                    OP_AND:   ;
                    OP_OR:    begin alu_nx = 1'b1; alu_ny = 1'b1; alu_asel = 1'b1; end
                    OP_XOR:   alu_l = 1'b1;
                    OP_NOT:   begin alu_zy = 1'b1; alu_ny = 1'b1; alu_asel = 1'b1; end
                    OP_NEG:   begin alu_nx = 1'b1; alu_zy = 1'b1; alu_f = 1'b1; alu_cs = 1'b1; alu_cin = 1'b1; end
                    OP_INC:   begin alu_zy = 1'b1; alu_f = 1'b1; alu_cs = 1'b1; alu_cin = 1'b1; end
                    OP_DEC:   begin alu_zy = 1'b1; alu_ny = 1'b1; alu_f = 1'b1; end
                    OP_PASSA: begin alu_zy = 1'b1; alu_ny = 1'b1; end
                    OP_PASSB: begin alu_zx = 1'b1; alu_nx = 1'b1; end
                    OP_MUL,
                    OP_ILL:   ;
                    default:  ;
                endcase
            end
            S_MUL: begin
                alu_x  = acc_q;
                alu_y  = mcand_q;
                alu_f  = 1'b1;
                alu_zy = ~mplr_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplr_d      = mplr_q;
        cnt_d       = cnt_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        res_wr_d    = res_wr_q;
        res_err_d   = res_err_q;
        flag_z_d    = flag_z_q;
        flag_n_d    = flag_n_q;
        flag_c_d    = flag_c_q;
        flag_v_d    = flag_v_q;
        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    opc_d = op_code;
                    a_d   = op_a;
                    b_d   = op_b;
                    if (op_code == OP_MUL) begin
                        acc_d   = '0;
                        mcand_d = op_a;
                        mplr_d  = op_b;
                        cnt_d   = '0;
                        state_d = S_MUL;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                res_valid_d = 1'b1;
                state_d     = S_DONE;
                if (opc_q == OP_ILL) begin
                    res_data_d = '0;
                    res_wr_d   = 1'b0;
                    res_err_d  = 1'b1;
                end else begin
                    res_data_d = alu_out;
                    res_wr_d   = (opc_q != OP_CMP);
                    res_err_d  = 1'b0;
                    flag_z_d   = (alu_out == '0);
                    flag_n_d   = alu_out[MSB];
                    if (carry_op) flag_c_d = alu_cout;
                    if (add_v_op) flag_v_d = v_add;
                    if (sub_v_op) flag_v_d = v_sub;
                end
            end
            S_MUL: begin
                acc_d   = alu_out;
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    res_data_d  = alu_out;
                    res_valid_d = 1'b1;
                    res_wr_d    = 1'b1;
                    res_err_d   = 1'b0;
                    flag_z_d    = (alu_out == '0);
                    flag_n_d    = alu_out[MSB];
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_wr_d    = 1'b0;
                    res_err_d   = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            opc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplr_q      <= '0;
            cnt_q       <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            res_wr_q    <= 1'b0;
            res_err_q   <= 1'b0;
            flag_z_q    <= 1'b0;
            flag_n_q    <= 1'b0;
            flag_c_q    <= 1'b0;
            flag_v_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplr_q      <= mplr_d;
            cnt_q       <= cnt_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            res_wr_q    <= res_wr_d;
            res_err_q   <= res_err_d;
            flag_z_q    <= flag_z_d;
            flag_n_q    <= flag_n_d;
            flag_c_q    <= flag_c_d;
            flag_v_q    <= flag_v_d;
        end
    end

    // op_ready also looks at rst so nothing is accepted while reset is asserted.
    assign op_ready  = (state_q == S_IDLE) && !rst;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_wr    = res_wr_q;
    assign res_err   = res_err_q;
    assign flag_z    = flag_z_q;
    assign flag_n    = flag_n_q;
    assign flag_c    = flag_c_q;
    assign flag_v    = flag_v_q;

endmodule
